// File: rtl/peecc_seq_ctrl.sv
// PEECC measurement sequencer: fills an N-stage pipeline, holds it for a measure window,
// hands off to TX and repeats per run. Optional TX watchdog via PEECC_SEQ_TXTIMEOUT_EN.
module peecc_seq_ctrl #(
  parameter int unsigned N_STAGES   = 5,
  parameter int unsigned CNT_W      = 11,
  parameter int unsigned RUN_W      = 8,
  parameter int unsigned TRIG_START = 1,
  parameter int unsigned TRIG_END   = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_in,
  input  logic                abort,
  input  logic [CNT_W-1:0]    dwell,
  input  logic [RUN_W-1:0]    num_runs,
  input  logic                tx_done,
  output logic [N_STAGES-1:0] stage_en,
  output logic                meas_en,
  output logic                trigger,
  output logic                start_tx,
  output logic                done,
  output logic                busy,
  output logic [RUN_W-1:0]    run_idx,
  output logic                tx_timeout
);

  localparam int unsigned K_W = (N_STAGES > 2) ? $clog2(N_STAGES) : 1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [RUN_W-1:0] RunOne = RUN_W'(1);
  localparam logic [K_W-1:0]   KOne   = K_W'(1);
  localparam logic [K_W-1:0]   KLast  = K_W'(N_STAGES - 1);
  localparam logic [CNT_W-1:0] TrigLo = CNT_W'(TRIG_START);
  localparam logic [CNT_W-1:0] TrigHi = CNT_W'(TRIG_END);

  typedef enum logic [2:0] {StIdle, StFill, StMeas, StTx, StDone} state_e;

  state_e           state_q, state_d;
  logic [K_W-1:0]   stage_q, stage_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic [RUN_W-1:0] runs_q, runs_d;
  logic [RUN_W-1:0] run_idx_q, run_idx_d;
  logic             tx_timeout_q, tx_timeout_d;
  logic             cnt_last, stage_last, run_last, wdog_hit;

  assign cnt_last   = (cnt_q == dwell_q - CntOne);
  assign stage_last = (stage_q == KLast);
  assign run_last   = (run_idx_q == runs_q - RunOne);

`ifdef PEECC_SEQ_TXTIMEOUT_EN
  // Counts completed TX cycles; timeout fires on the edge where it would reach all-ones.
  localparam logic [CNT_W-1:0] WdogHit = {CNT_W{1'b1}} - CntOne;
  logic [CNT_W-1:0] wdog_q, wdog_d;

  assign wdog_hit = (wdog_q == WdogHit);
  assign wdog_d   = (state_q == StTx) ? wdog_q + CntOne : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wdog_q <= '0;
    else       wdog_q <= wdog_d;
  end
`else
  assign wdog_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      stage_q      <= '0;
      cnt_q        <= '0;
      dwell_q      <= '0;
      runs_q       <= '0;
      run_idx_q    <= '0;
      tx_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      stage_q      <= stage_d;
      cnt_q        <= cnt_d;
      dwell_q      <= dwell_d;
      runs_q       <= runs_d;
      run_idx_q    <= run_idx_d;
      tx_timeout_q <= tx_timeout_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    stage_d      = stage_q;
    cnt_d        = cnt_q;
    dwell_d      = dwell_q;
    runs_d       = runs_q;
    run_idx_d    = run_idx_q;
    tx_timeout_d = tx_timeout_q;
    if (abort && (state_q != StIdle)) begin
      // Abort outranks every terminal condition and leaves all outputs cleared.
      state_d      = StIdle;
      stage_d      = '0;
      cnt_d        = '0;
      run_idx_d    = '0;
      tx_timeout_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (valid_in && !abort) begin
            state_d      = StFill;
            stage_d      = '0;
            cnt_d        = '0;
            dwell_d      = (dwell == '0) ? CntOne : dwell;
            runs_d       = (num_runs == '0) ? RunOne : num_runs;
            run_idx_d    = '0;
            tx_timeout_d = 1'b0;
          end
        end
        StFill: begin
          if (cnt_last) begin
            cnt_d = '0;
            if (stage_last) begin
              stage_d = '0;
              state_d = StMeas;
            end else begin
              stage_d = stage_q + KOne;
            end
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        StMeas: begin
          if (cnt_last) begin
            cnt_d   = '0;
            state_d = StTx;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        StTx: begin
          if (tx_done) begin
            if (run_last) begin
              state_d = StDone;
            end else begin
              run_idx_d = run_idx_q + RunOne;
              state_d   = StMeas;
            end
          end else if (wdog_hit) begin
            tx_timeout_d = 1'b1;
            state_d      = StDone;
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    stage_en = '0;
    meas_en  = 1'b0;
    trigger  = 1'b0;
    start_tx = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      StFill: begin
        for (int unsigned i = 0; i < N_STAGES; i++) begin
          stage_en[i] = (32'(stage_q) >= i);
        end
        trigger = (stage_q == '0) && (cnt_q >= TrigLo) && (cnt_q <= TrigHi);
      end
      StMeas: begin
        stage_en = '1;
        meas_en  = 1'b1;
      end
      StTx:    start_tx = 1'b1;
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  assign busy       = (state_q != StIdle);
  assign run_idx    = run_idx_q;
  assign tx_timeout = tx_timeout_q;

endmodule

// File: doc/peecc_seq_ctrl.md
Name: peecc_seq_ctrl

Overview:
Parametrised sequencer for the PEECC measurement pipeline (data gen -> encoder -> bus -> decoder -> metrics).
- Fills an N-stage pipeline one stage at a time, then holds it full for a measurement window.
- Hands results to the UART/TX path and repeats for a programmable number of runs.
- Supersedes the fixed 5-stage controller: stage count, dwell time, trigger window and run count are all configurable.

Parameters:
N_STAGES, 5, number of pipeline stage enables (>=2)
CNT_W, 11, width of dwell counter and dwell input
RUN_W, 8, width of run counter and num_runs input
TRIG_START, 1, first dwell count (inclusive) of the trigger window in fill stage 0
TRIG_END, 3, last dwell count (inclusive) of the trigger window; TRIG_START<=TRIG_END<2^CNT_W

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
valid_in  in  1  start request; sampled only in IDLE
abort  in  1  synchronous abort; returns to IDLE from any state
dwell  in  CNT_W  cycles per stage/measure window; latched at start; 0 treated as 1
num_runs  in  RUN_W  measurement runs per start; latched at start; 0 treated as 1
tx_done  in  1  TX path finished sending results
stage_en  out  N_STAGES  thermometer stage enables (bit0 = data gen)
meas_en  out  1  enables transition counter / bit-flip / k-comparison blocks
trigger  out  1  scope/ILA trigger window
start_tx  out  1  request to TX path; held until tx_done
done  out  1  one-cycle pulse at end of all runs
busy  out  1  state != IDLE
run_idx  out  RUN_W  index of current run (0-based)
tx_timeout  out  1  sticky timeout flag (see Optional Feature)

Behaviour:
- Reset:
  - state=IDLE; all counters 0.
  - All outputs 0, including stage_en=0 and run_idx=0.
- Output decoding: all outputs are Moore, decoded only from registered state/counters. No combinational input-to-output paths.
- D = max(dwell,1) and R = max(num_runs,1) are latched on the IDLE->FILL transition. Later changes to dwell/num_runs have no effect until the next start.
- States: IDLE, FILL, MEAS, TX, DONE.
- IDLE:
  - valid_in=1 at edge t -> FILL with stage k=0, cnt=0 from cycle t+1.
  - Clears run_idx and tx_timeout.
- FILL:
  - stage_en[i]=1 for i<=k.
  - cnt counts 0..D-1; at cnt=D-1, cnt wraps to 0 and k increments.
  - After stage k=N_STAGES-1 completes -> MEAS.
  - Each stage lasts exactly D cycles.
- trigger=1 iff state=FILL, k=0 and TRIG_START<=cnt<=TRIG_END.
  - If D<=TRIG_START, trigger never asserts.
  - If D-1<TRIG_END, the window truncates at D-1.
- MEAS: stage_en all ones, meas_en=1, for exactly D cycles -> TX.
- TX:
  - stage_en=0, meas_en=0, start_tx=1.
  - tx_done sampled high (including in the first TX cycle) -> exit.
  - Exit: if run_idx+1<R, run_idx increments and state -> MEAS; otherwise -> DONE. The pipeline refills in MEAS with no new FILL phase.
- DONE: done=1 for one cycle -> IDLE. run_idx holds its final value until the next start.
- Counter rules:
  - cnt never exceeds D-1. Wrap at 2^CNT_W is impossible because D<=2^CNT_W-1.
  - run_idx never exceeds R-1.
- Ignored inputs: valid_in outside IDLE; tx_done outside TX.
- abort:
  - Forces IDLE on the next edge from FILL/MEAS/TX/DONE, with no done pulse.
  - abort has priority over tx_done and over the counter-terminal transitions in the same cycle.
  - abort together with valid_in in IDLE: stay in IDLE.
- reset asserted mid-operation: immediate return to reset values, regardless of clock.

Optional Feature:
PEECC_SEQ_TXTIMEOUT_EN
- Defined:
  - A CNT_W-bit watchdog counts TX cycles, restarting at 0 on each TX entry.
  - If it reaches 2^CNT_W-1 without tx_done: tx_timeout<=1 (sticky until the next start) and state -> DONE. done still pulses and remaining runs are skipped.
  - tx_done in the same cycle as the terminal count wins (normal exit, no timeout).
- Undefined: TX waits for tx_done indefinitely; tx_timeout is tied to 0.

Test Plan:
1. N_STAGES=5, dwell=4, num_runs=1, valid_in at cycle 0, tx_done at cycle 27 -> expected response:
   - stage_en=00001 (cycles 1-4), 00011 (5-8), 00111 (9-12), 01111 (13-16), 11111 (17-20).
   - meas_en=1 and stage_en=11111 in cycles 21-24.
   - trigger=1 in cycles 2-4.
   - start_tx=1 in cycles 25-27; done=1 in cycle 28; busy=0 from cycle 29.
2. dwell=0, num_runs=0 -> behaves as dwell=1, runs=1: each stage lasts 1 cycle, trigger never asserts, exactly one done pulse.
3. dwell=2, num_runs=3, tx_done returned 2 cycles after each start_tx rise -> three MEAS windows of 2 cycles each, run_idx=0,1,2, one done pulse after the third TX, no re-FILL between runs.
4. abort asserted in the 3rd FILL stage, and separately in the same cycle as tx_done -> IDLE next cycle, all outputs 0, no done pulse. valid_in during FILL is ignored.
5. reset pulsed asynchronously (between clock edges) during MEAS -> outputs 0 immediately. A subsequent valid_in starts cleanly from stage 0 with a fresh latch of dwell/num_runs.
6. With PEECC_SEQ_TXTIMEOUT_EN, CNT_W=4, tx_done held 0 -> after 15 TX cycles tx_timeout=1 and done pulses. Without the macro, start_tx stays 1 indefinitely and tx_timeout=0.
